// File: rtl/vi_mem_pkg.sv
// Shared types and helpers for the vi_mem responder slice.
package vi_mem_pkg;

  localparam int MEM_WORD_W = 32;
  localparam int MEM_BE_W   = 4;

  typedef struct packed {
    logic [MEM_WORD_W-1:0] rdata;
    logic                  error;
  } mem_rsp_t;

  // A request is rejected if it is not word aligned or falls past the end of the array.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/vi_mem_rsp_fifo.sv
// Response FIFO with first-word fall-through; shows zeros while empty.
module vi_mem_rsp_fifo
  import vi_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  mem_rsp_t wr_data,
  input  logic     rd_en,
  output logic     empty,
  output mem_rsp_t rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  mem_rsp_t      store [DEPTH];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : store[rd_ptr];

  // Push/pop bookkeeping; the requester's credit limit keeps writes off a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        store[wr_ptr] <= wr_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/vi_mem_responder.sv
// Memory-side responder: word array, fixed-latency response pipe, in-order response FIFO
// and credit-based request back-pressure.
// Optional build macro VI_MEM_STALL_INJECT_EN adds an LFSR that randomly drops req_ready_o.
module vi_mem_responder
  import vi_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 5,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [MEM_WORD_W-1:0] req_wdata_i,
  input  logic [MEM_BE_W-1:0]   req_byte_en_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [MEM_WORD_W-1:0] rsp_rdata_o,
  output logic                  rsp_error_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CRD_W = $clog2(QUEUE_DEPTH + 1);

  logic [MEM_WORD_W-1:0] mem [DEPTH_WORDS];
  logic [CRD_W-1:0]      credits;
  logic [IDX_W-1:0]      word_idx;
  logic                  req_bad;
  logic                  accept;
  logic                  rsp_fire;
  logic                  stall_inj;
  logic                  fifo_wr;
  logic                  fifo_empty;
  mem_rsp_t              acc_rsp;
  mem_rsp_t              fifo_in;
  mem_rsp_t              fifo_out;

  assign word_idx    = req_addr_i[IDX_W+1:2];
  assign req_bad     = addr_bad(req_addr_i, DEPTH_WORDS);
  assign req_ready_o = (credits < CRD_W'(QUEUE_DEPTH)) & ~stall_inj;
  assign accept      = req_valid_i & req_ready_o;
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;

  // Response is formed in the accept cycle, so a read sees every earlier-accepted write.
  always_comb begin
    acc_rsp       = '0;
    acc_rsp.error = req_bad;
    if (!req_bad && !req_write_i) begin
      acc_rsp.rdata = mem[word_idx];
    end
  end

  // Byte-masked array write; the array itself is never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (accept && !rsn_i && req_write_i && !req_bad) begin
      for (int b = 0; b < MEM_BE_W; b++) begin
        if (req_byte_en_i[b]) begin
          mem[word_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // The FIFO write costs one cycle, so the delay pipe is LATENCY-1 stages deep.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign fifo_wr = accept;
      assign fifo_in = acc_rsp;
    end else begin : g_pipe
      localparam int PD = LATENCY - 1;
      logic [PD-1:0] pipe_v;
      mem_rsp_t      pipe_d [PD];

      // Free-running shift pipe; it never stalls, the FIFO absorbs consumer stalls.
      always_ff @(posedge clk_i) begin
        if (rsn_i) begin
          pipe_v <= '0;
        end else begin
          pipe_v[0] <= accept;
          pipe_d[0] <= acc_rsp;
          for (int i = 1; i < PD; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
          end
        end
      end

      assign fifo_wr = pipe_v[PD-1];
      assign fifo_in = pipe_d[PD-1];
    end
  endgenerate

  // Outstanding-request count: pipe plus FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      credits <= '0;
    end else if (accept && !rsp_fire) begin
      credits <= credits + 1'b1;
    end else if (!accept && rsp_fire) begin
      credits <= credits - 1'b1;
    end
  end

`ifdef VI_MEM_STALL_INJECT_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1 used to inject pseudo-random request stalls.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign stall_inj = lfsr[0];
`else
  assign stall_inj = 1'b0;
`endif

  vi_mem_rsp_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk_i),
    .rst     (rsn_i),
    .wr_en   (fifo_wr),
    .wr_data (fifo_in),
    .rd_en   (rsp_fire),
    .empty   (fifo_empty),
    .rd_data (fifo_out)
  );

  assign rsp_valid_o = ~fifo_empty;
  assign rsp_rdata_o = fifo_out.rdata;
  assign rsp_error_o = fifo_out.error;

endmodule
